// File: rtl/decode_pkg.sv
// decode_pkg: shared opcode constants, ALU operation encoding and decoded-instruction bundle
package decode_pkg;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;
    logic       reg_write, mem_read, mem_write, branch, jump, illegal, muldiv;
    alu_op_e    alu_op;
  } decoded_t;
endpackage

// File: rtl/instr_field_decode.sv
// instr_field_decode: combinational field, immediate and control decode of one RV32/64 instruction
// Define MEXT_EN to decode the M extension (funct7=0000001 under OP).
module instr_field_decode import decode_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output decoded_t        dec_o,
  output logic [XLEN-1:0] imm_o
);
  logic [6:0] op, f7, shu;
  logic [2:0] f3;
  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
  logic muldiv, op_ok, imm_ok, illegal;
  alu_op_e arith;
  assign op = instr_i[6:0];
  assign f3 = instr_i[14:12];
  assign f7 = instr_i[31:25];
  // RV64 shifts use a 6-bit shamt, so only instr[31:26] must be checked
  assign shu = (XLEN == 64) ? {instr_i[31:26], 1'b0} : f7;
  assign is_lui    = op == OPC_LUI;
  assign is_auipc  = op == OPC_AUIPC;
  assign is_jal    = op == OPC_JAL;
  assign is_jalr   = op == OPC_JALR;
  assign is_branch = op == OPC_BRANCH;
  assign is_load   = op == OPC_LOAD;
  assign is_store  = op == OPC_STORE;
  assign is_opimm  = op == OPC_OP_IMM;
  assign is_op     = op == OPC_OP;
`ifdef MEXT_EN
  assign muldiv = is_op && f7 == 7'b0000001;
`else
  assign muldiv = 1'b0;
`endif
  assign op_ok  = f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) || muldiv;
  assign imm_ok = f3 == 3'b001 ? shu == 7'b0 :
                  f3 == 3'b101 ? (shu == 7'b0 || shu == 7'b0100000) : 1'b1;
  assign illegal = instr_i[1:0] != 2'b11 ||
                   !(is_lui || is_auipc || is_jal || is_jalr || is_branch || is_load || is_store ||
                     (is_opimm && imm_ok) || (is_op && op_ok));
  assign arith = f3 == 3'b000 ? ((is_op && f7[5]) ? ALU_SUB : ALU_ADD) :
                 f3 == 3'b001 ? ALU_SLL :
                 f3 == 3'b010 ? ALU_SLT :
                 f3 == 3'b011 ? ALU_SLTU :
                 f3 == 3'b100 ? ALU_XOR :
                 f3 == 3'b101 ? (instr_i[30] ? ALU_SRA : ALU_SRL) :
                 f3 == 3'b110 ? ALU_OR : ALU_AND;
  assign imm_o = (is_opimm || is_load || is_jalr) ? XLEN'($signed(instr_i[31:20])) :
                 is_store  ? XLEN'($signed({instr_i[31:25], instr_i[11:7]})) :
                 is_branch ? XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0})) :
                 (is_lui || is_auipc) ? XLEN'($signed({instr_i[31:12], 12'b0})) :
                 is_jal    ? XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0})) :
                 '0;
  always_comb begin
    dec_o           = '0;
    dec_o.opcode    = op;
    dec_o.rd        = instr_i[11:7];
    dec_o.rs1       = instr_i[19:15];
    dec_o.rs2       = instr_i[24:20];
    dec_o.funct3    = f3;
    dec_o.illegal   = illegal;
    dec_o.muldiv    = muldiv;
    dec_o.reg_write = !illegal && instr_i[11:7] != 5'd0 &&
                      (is_lui || is_auipc || is_jal || is_jalr || is_load || is_opimm || is_op);
    dec_o.mem_read  = !illegal && is_load;
    dec_o.mem_write = !illegal && is_store;
    dec_o.branch    = !illegal && is_branch;
    dec_o.jump      = !illegal && (is_jal || is_jalr);
    dec_o.alu_op    = ((is_op || is_opimm) && !muldiv) ? arith :
                      is_lui ? ALU_PASSB : is_branch ? ALU_SUB : ALU_ADD;
  end
endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: decode stage with a 2-entry (main + skid) elastic buffer
// Define MEXT_EN to decode MUL/DIV/REM; otherwise they are flagged illegal.
module instr_decode_stage import decode_pkg::*; #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [XLEN-1:0] out_imm,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal,
  output logic [3:0]      out_alu_op,
  output logic            out_muldiv
);
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] imm;
    decoded_t        dec;
  } entry_t;
  decoded_t dec;
  logic [XLEN-1:0] imm;
  entry_t in_e, main_q, main_d, skid_q, skid_d;
  logic main_v_q, main_v_d, skid_v_q, skid_v_d, acc, deq;
  instr_field_decode #(.XLEN(XLEN)) u_field_decode (
    .instr_i(in_instr),
    .dec_o  (dec),
    .imm_o  (imm)
  );
  assign in_e = '{pc: in_pc, imm: imm, dec: dec};
  assign in_ready = !skid_v_q;
  assign acc = in_valid && in_ready && !flush;
  assign deq = main_v_q && out_ready;
  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (skid_v_q) begin
      if (deq) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end
    end else if (acc) begin
      if (main_v_q && !out_ready) begin
        skid_d   = in_e;
        skid_v_d = 1'b1;
      end else begin
        main_d   = in_e;
        main_v_d = 1'b1;
      end
    end else if (deq) begin
      main_v_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end
  assign out_valid     = main_v_q;
  assign out_pc        = main_q.pc;
  assign out_imm       = main_q.imm;
  assign out_opcode    = main_q.dec.opcode;
  assign out_rd        = main_q.dec.rd;
  assign out_rs1       = main_q.dec.rs1;
  assign out_rs2       = main_q.dec.rs2;
  assign out_funct3    = main_q.dec.funct3;
  assign out_reg_write = main_q.dec.reg_write;
  assign out_mem_read  = main_q.dec.mem_read;
  assign out_mem_write = main_q.dec.mem_write;
  assign out_branch    = main_q.dec.branch;
  assign out_jump      = main_q.dec.jump;
  assign out_illegal   = main_q.dec.illegal;
  assign out_alu_op    = main_q.dec.alu_op;
  assign out_muldiv    = main_q.dec.muldiv;
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: directed self-checking bench for instr_decode_stage
module tb_instr_decode_stage;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_imm;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic        out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal, out_muldiv;
  logic [3:0]  out_alu_op;
  int n_tests = 0, n_fail = 0;
  instr_decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3), .out_imm(out_imm),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_branch(out_branch), .out_jump(out_jump), .out_illegal(out_illegal), .out_alu_op(out_alu_op),
    .out_muldiv(out_muldiv)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_imm", out_imm, 0);
    check("rst_pc", out_pc, 0);
    rst = 1'b0;
    push(32'h003100B3, 32'h100);
    check("add_valid", out_valid, 1);
    check("add_rd", out_rd, 1);
    check("add_rs1", out_rs1, 2);
    check("add_rs2", out_rs2, 3);
    check("add_alu", out_alu_op, 0);
    check("add_rw", out_reg_write, 1);
    check("add_imm", out_imm, 0);
    check("add_pc", out_pc, 32'h100);
    check("add_ill", out_illegal, 0);
    tick();
    check("add_drain", out_valid, 0);
    push(32'hFE208EE3, 32'h104);
    check("beq_imm", out_imm, 32'hFFFFFFFC);
    check("beq_br", out_branch, 1);
    check("beq_alu", out_alu_op, 1);
    check("beq_rw", out_reg_write, 0);
    push(32'h403100B3, 32'h108);
    check("sub_alu", out_alu_op, 1);
    push(32'h40315093, 32'h10C);
    check("srai_alu", out_alu_op, 7);
    check("srai_ill", out_illegal, 0);
    push(32'h123452B7, 32'h110);
    check("lui_imm", out_imm, 32'h12345000);
    check("lui_alu", out_alu_op, 10);
    check("lui_rw", out_reg_write, 1);
    push(32'h403110B3, 32'h114);
    check("sll_f7_ill", out_illegal, 1);
    check("sll_f7_rw", out_reg_write, 0);
    push(32'h023100B3, 32'h118);
`ifdef MEXT_EN
    check("mul_md", out_muldiv, 1);
    check("mul_ill", out_illegal, 0);
    check("mul_rw", out_reg_write, 1);
    check("mul_alu", out_alu_op, 0);
`else
    check("mul_md", out_muldiv, 0);
    check("mul_ill", out_illegal, 1);
    check("mul_rw", out_reg_write, 0);
`endif
    push(32'hFFFFFFFF, 32'h11C);
    check("ff_valid", out_valid, 1);
    check("ff_ill", out_illegal, 1);
    check("ff_ctrl", {out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump}, 0);
    push(32'h00000013, 32'h120);
    check("nop_ill", out_illegal, 0);
    check("nop_rw", out_reg_write, 0);
    tick();
    out_ready = 1'b0;
    push(32'h00510093, 32'h10);
    check("s_rdy1", in_ready, 1);
    push(32'h01012083, 32'h14);
    check("s_rdy2", in_ready, 0);
    in_valid = 1'b1;
    in_instr = 32'h00112A23;
    in_pc    = 32'h18;
    tick();
    check("s_hold_rdy", in_ready, 0);
    check("s_hold_valid", out_valid, 1);
    check("s_addi_imm", out_imm, 5);
    check("s_addi_pc", out_pc, 32'h10);
    out_ready = 1'b1;
    tick();
    check("s_lw_imm", out_imm, 16);
    check("s_lw_mr", out_mem_read, 1);
    check("s_lw_pc", out_pc, 32'h14);
    tick();
    in_valid = 1'b0;
    check("s_sw_imm", out_imm, 20);
    check("s_sw_mw", out_mem_write, 1);
    check("s_sw_pc", out_pc, 32'h18);
    tick();
    check("s_empty", out_valid, 0);
    out_ready = 1'b0;
    push(32'h020000EF, 32'h200);
    check("jal_jump", out_jump, 1);
    check("jal_imm", out_imm, 32);
    push(32'h003100B3, 32'h204);
    check("fl_full", in_ready, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_valid", out_valid, 0);
    check("fl_rdy", in_ready, 1);
    flush    = 1'b1;
    in_valid = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_ignore", out_valid, 0);
    out_ready = 1'b1;
    tick();
    check("fl_no_jal", out_valid, 0);
    out_ready = 1'b0;
    push(32'h00510093, 32'h300);
    push(32'h01012083, 32'h304);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rs_valid", out_valid, 0);
    check("rs_rdy", in_ready, 1);
    check("rs_pc", out_pc, 0);
    check("rs_imm", out_imm, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
